mouse_axis_acc: RTL and testbench

- Parametrised successor to the single-axis mouse direction emulator.
- Converts per-packet signed mouse deltas on NUM_AXES axes into joystick-style direction pulses. Each pulse represents STEP units of motion and is held until the host scans the joystick row.
- Deltas accumulate in a saturating counter, so packets arriving before earlier motion is drained are added to it, not overwritten.
- Adds an enforced minimum pulse width, a pending-clear mechanism and sticky overflow flags.
- Sits between the PS/2 mouse decoder and the keyboard/joystick matrix mux in the HID block.

---
 rtl/mouse_axis_acc.sv | 133 +++++++++++++
 tb/tb_mouse_axis_acc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mouse_axis_acc.sv
// Multi-axis mouse-delta to joystick-direction converter: saturating per-axis
// accumulators drained one STEP at a time into scan-acknowledged dir pulses.
module mouse_axis_acc #(
  parameter int NUM_AXES = 2,
  parameter int IN_W     = 9,
  parameter int ACC_W    = 12,
  parameter int STEP     = 2,
  parameter int MIN_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     set,
  input  logic [NUM_AXES*IN_W-1:0] delta,
  input  logic                     scan,
  input  logic                     clr_ovf,
  output logic [2*NUM_AXES-1:0]    dir,
  output logic [NUM_AXES-1:0]      busy,
  output logic [NUM_AXES-1:0]      overflow
);

  localparam int HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
  localparam int SUM_W  = ACC_W + 2;

  localparam logic signed [ACC_W-1:0] STEP_A  = ACC_W'(STEP);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [HOLD_W-1:0]       HOLD_MAX = HOLD_W'(MIN_HOLD);

  typedef enum logic {
    S_IDLE,
    S_ASSERT
  } state_t;

  logic r_scan_q;
  logic w_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_scan_q <= 1'b0;
    else          r_scan_q <= scan;
  end

  assign w_rise = scan & ~r_scan_q;

  for (genvar gk = 0; gk < NUM_AXES; gk++) begin : g_axis
    state_t                   r_state, w_state_nx;
    logic signed [ACC_W-1:0]  r_acc, w_acc_nx;
    logic [HOLD_W-1:0]        r_hold, w_hold_nx, w_hold_inc;
    logic                     r_pend, w_pend_nx;
    logic [1:0]               r_dir, w_dir_nx;
    logic                     r_ovf, w_ovf_nx;
    logic                     r_busy;
    logic signed [IN_W-1:0]   w_delta;
    logic signed [ACC_W-1:0]  w_cons;
    logic signed [SUM_W-1:0]  w_add, w_sum;
    logic                     w_sat;

    assign w_delta = delta[gk*IN_W +: IN_W];

    always_comb begin
      w_state_nx = r_state;
      w_hold_nx  = r_hold;
      w_pend_nx  = r_pend;
      w_dir_nx   = r_dir;
      w_cons     = '0;
      w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : r_hold + HOLD_W'(1);
      case (r_state)
        S_IDLE: begin
          w_dir_nx = '0;
          if (r_acc != '0) begin
            if (!r_acc[ACC_W-1]) begin
              w_cons   = (r_acc > STEP_A) ? STEP_A : r_acc;
              w_dir_nx = 2'b01;
            end else begin
              // Compared against -STEP so the most negative value never gets negated.
              w_cons   = (r_acc < -STEP_A) ? -STEP_A : r_acc;
              w_dir_nx = 2'b10;
            end
            w_hold_nx  = '0;
            w_pend_nx  = 1'b0;
            w_state_nx = S_ASSERT;
          end
        end
        S_ASSERT: begin
          w_hold_nx = w_hold_inc;
          if (w_rise) w_pend_nx = 1'b1;
          // Post-increment count keeps dir high for exactly MIN_HOLD cycles.
          if ((r_pend || w_rise) && (w_hold_inc >= HOLD_MAX)) begin
            w_dir_nx   = '0;
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    always_comb begin
      w_add = '0;
      if (set) w_add = SUM_W'(w_delta);
      w_sum = SUM_W'(r_acc) - SUM_W'(w_cons) + w_add;
      w_sat = !((&w_sum[SUM_W-1:ACC_W-1]) || (~|w_sum[SUM_W-1:ACC_W-1]));
      w_acc_nx = w_sum[ACC_W-1:0];
      if (w_sat) w_acc_nx = w_sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      w_ovf_nx = r_ovf;
      if (w_sat)        w_ovf_nx = 1'b1;
      else if (clr_ovf) w_ovf_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_hold  <= '0;
        r_pend  <= 1'b0;
        r_dir   <= '0;
        r_ovf   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_acc   <= w_acc_nx;
        r_hold  <= w_hold_nx;
        r_pend  <= w_pend_nx;
        r_dir   <= w_dir_nx;
        r_ovf   <= w_ovf_nx;
        r_busy  <= (w_acc_nx != '0) || (w_state_nx == S_ASSERT);
      end
    end

    assign dir[2*gk +: 2] = r_dir;
    assign busy[gk]       = r_busy;
    assign overflow[gk]   = r_ovf;
  end

endmodule

// File: tb/tb_mouse_axis_acc.sv
// Directed bench for mouse_axis_acc: expected pulses are queued per axis when
// deltas are driven and popped by a monitor as dir pulses appear.
module tb_mouse_axis_acc;
  localparam int NA = 2;
  localparam int IW = 9;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            set = 1'b0;
  logic            scan = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [NA*IW-1:0] delta = '0;
  logic [2*NA-1:0] dir;
  logic [NA-1:0]   busy;
  logic [NA-1:0]   overflow;

  int n_assert = 0;
  int n_fail   = 0;
  bit q0[$];
  bit q1[$];
  logic [2*NA-1:0] dir_prev = '0;
  bit mon_en = 1'b0;

  mouse_axis_acc #(
    .NUM_AXES(2),
    .IN_W(9),
    .ACC_W(12),
    .STEP(2),
    .MIN_HOLD(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .set(set),
    .delta(delta),
    .scan(scan),
    .clr_ovf(clr_ovf),
    .dir(dir),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] cur, prv;
    bit has, eneg;
    if (mon_en) begin
      for (int k = 0; k < NA; k++) begin
        cur = dir[2*k +: 2];
        prv = dir_prev[2*k +: 2];
        chk($sformatf("dir_onehot_ax%0d", k), 32'(cur == 2'b11), 0);
        if (cur != 2'b00 && cur != prv) begin
          chk($sformatf("idle_gap_ax%0d", k), 32'(prv), 0);
          has  = 1'b0;
          eneg = 1'b0;
          if (k == 0) begin
            has = (q0.size() > 0);
            if (has) eneg = q0.pop_front();
          end else begin
            has = (q1.size() > 0);
            if (has) eneg = q1.pop_front();
          end
          chk($sformatf("pulse_expected_ax%0d", k), 32'(has), 1);
          if (has) chk($sformatf("pulse_sign_ax%0d", k), 32'(cur), eneg ? 32'd2 : 32'd1);
        end
      end
    end
    dir_prev = dir;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_set(input int d0, input int d1);
    delta = {IW'(d1), IW'(d0)};
    set   = 1'b1;
    tick();
    set   = 1'b0;
    delta = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy != '0) && (n < budget)) begin
      scan = 1'b1;
      tick();
      scan = 1'b0;
      tick();
      tick();
      n += 3;
    end
    tick();
    chk({tag, "_busy_drained"}, 32'(busy), 0);
    chk({tag, "_dir_idle"}, 32'(dir), 0);
    chk({tag, "_q0_left"}, 32'(q0.size()), 0);
    chk({tag, "_q1_left"}, 32'(q1.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_dir", 32'(dir), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Test 1: +5 with STEP 2 -> three pos pulses on axis 0
    repeat (3) q0.push_back(1'b0);
    drive_set(5, 0);
    chk("t1_busy_after_set", 32'(busy), 1);
    drain("t1", 300);

    // Test 2: -3 then -4 on axis 1 -> four neg pulses
    repeat (4) q1.push_back(1'b1);
    drive_set(0, -3);
    drive_set(0, -4);
    drain("t2", 300);

    // Test 3: minimum hold with an early scan rise
    q0.push_back(1'b0);
    drive_set(1, 0);
    n = 0;
    while (!dir[0] && n < 10) begin
      tick();
      n++;
    end
    chk("t3_dir_rise", 32'(dir[0]), 1);
    chk("t3_rise_latency", 32'(n), 1);
    w = 0;
    while (dir[0] && w < 20) begin
      w++;
      tick();
      if (w == 1) scan = 1'b1;
    end
    chk("t3_width", 32'(w), 4);
    scan = 1'b0;
    tick();
    chk("t3_busy", 32'(busy), 0);
    chk("t3_q0_left", 32'(q0.size()), 0);

    // Test 4: saturation at 2047, overflow stickiness and clear
    repeat (1025) q0.push_back(1'b0);
    repeat (20) drive_set(255, 0);
    chk("t4_ovf_set", 32'(overflow), 1);
    chk("t4_busy", 32'(busy), 1);
    clr_ovf = 1'b1;
    drive_set(255, 0);
    clr_ovf = 1'b0;
    chk("t4_ovf_set_wins", 32'(overflow), 1);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 0);
    drain("t4", 15000);

    // Test 5: +4 then -4 -> one pos pulse then one neg pulse
    q0.push_back(1'b0);
    q0.push_back(1'b1);
    drive_set(4, 0);
    drive_set(-4, 0);
    drain("t5", 300);

    // Test 6: asynchronous reset mid-pulse
    q0.push_back(1'b0);
    q1.push_back(1'b1);
    drive_set(102, -255);
    repeat (8) drive_set(0, -255);
    repeat (3) tick();
    chk("t6_pre_dir0", 32'(dir[0]), 1);
    chk("t6_pre_ovf", 32'(overflow), 2);
    chk("t6_pre_busy", 32'(busy), 3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_dir", 32'(dir), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) begin
      scan = 1'b1;
      tick();
      scan = 1'b0;
      tick();
      tick();
    end
    chk("t6_post_dir", 32'(dir), 0);
    chk("t6_post_busy", 32'(busy), 0);
    chk("t6_post_ovf", 32'(overflow), 0);
    chk("t6_q0_left", 32'(q0.size()), 0);
    chk("t6_q1_left", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
